fp32_div_arbiter: RTL and testbench

- Shares one fully pipelined fixed-latency FP32 divider (fp32_div) between N requesters using round-robin arbitration.
- Accepts at most one division per cycle and issues it to the divider.
- Carries a requester tag alongside each operation through a shadow pipeline, and returns each quotient to its originator.
- Sits between the force/position compute units and the single instantiated divider.

---
 rtl/fp32_div_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fp32_div_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 divider between N requesters.
// A tag shadow pipeline carries {valid, id, dbz} alongside each division so the
// quotient can be routed back to the requester that issued it.
module fp32_div_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned DIV_LATENCY = 28,
  parameter int unsigned IDW         = 2,
  localparam int unsigned CW         = $clog2(DIV_LATENCY + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       div_a,
  output logic [31:0]       div_b,
  output logic              div_valid,
  input  logic [31:0]       div_result,
  output logic [N-1:0]      res_valid,
  output logic [31:0]       res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_dbz,
  output logic [CW-1:0]     inflight,
  output logic              idle
);

  localparam logic [IDW-1:0] LastId = IDW'(N - 1);

  // Arbitration
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic [31:0]    grant_a, grant_b;
  logic           found;
  int             arb_idx;
  logic           accept;

  // Issue stage
  logic           div_valid_q, div_valid_d;
  logic [31:0]    div_a_q, div_a_d;
  logic [31:0]    div_b_q, div_b_d;
  logic [IDW-1:0] iss_id_q, iss_id_d;
  logic           iss_dbz_q, iss_dbz_d;

  // Tag shadow pipeline
  logic [DIV_LATENCY-1:0]          tag_v_q, tag_v_d;
  logic [DIV_LATENCY-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [DIV_LATENCY-1:0]          tag_dbz_q, tag_dbz_d;

  // Return stage
  logic [N-1:0]   res_valid_q, res_valid_d;
  logic [31:0]    res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_dbz_q, res_dbz_d;

  logic [CW-1:0]  inflight_q, inflight_d;
  logic           ret;

  // Round-robin search starting at the pointer; grants are suppressed during reset
  always_comb begin
    grant    = '0;
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    found    = 1'b0;
    arb_idx  = 0;
    for (int k = 0; k < int'(N); k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= int'(N)) arb_idx = arb_idx - int'(N);
      if (!found && req_valid[arb_idx]) begin
        found          = 1'b1;
        grant[arb_idx] = 1'b1;
        grant_id       = IDW'(arb_idx);
        grant_a        = req_a[32*arb_idx +: 32];
        grant_b        = req_b[32*arb_idx +: 32];
      end
    end
    if (rst) grant = '0;
  end

  assign accept    = |grant;
  assign req_ready = grant;

  // Next-state for pointer, issue registers, tag pipeline, return stage and counter
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_id == LastId) ? '0 : grant_id + IDW'(1);

    div_valid_d = accept;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    iss_id_d    = iss_id_q;
    iss_dbz_d   = iss_dbz_q;
    if (accept) begin
      div_a_d   = grant_a;
      div_b_d   = grant_b;
      iss_id_d  = grant_id;
      // Both +0 and -0 count as a zero denominator
      iss_dbz_d = (grant_b[30:0] == 31'd0);
    end

    tag_v_d      = '0;
    tag_id_d     = '0;
    tag_dbz_d    = '0;
    tag_v_d[0]   = div_valid_q;
    tag_id_d[0]  = iss_id_q;
    tag_dbz_d[0] = iss_dbz_q;
    for (int k = 1; k < int'(DIV_LATENCY); k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
      tag_dbz_d[k] = tag_dbz_q[k-1];
    end

    res_valid_d = '0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_dbz_d   = res_dbz_q;
    // The tag leaves the pipeline in the same cycle the divider presents its quotient
    if (tag_v_q[DIV_LATENCY-1]) begin
      res_valid_d[tag_id_q[DIV_LATENCY-1]] = 1'b1;
      res_data_d = div_result;
      res_id_d   = tag_id_q[DIV_LATENCY-1];
      res_dbz_d  = tag_dbz_q[DIV_LATENCY-1];
    end

    inflight_d = inflight_q;
    if (accept && !ret) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!accept && ret) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  assign ret = |res_valid_q;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      div_valid_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      iss_id_q    <= '0;
      iss_dbz_q   <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      tag_dbz_q   <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_dbz_q   <= 1'b0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      div_valid_q <= div_valid_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      iss_id_q    <= iss_id_d;
      iss_dbz_q   <= iss_dbz_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      tag_dbz_q   <= tag_dbz_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_dbz_q   <= res_dbz_d;
      inflight_q  <= inflight_d;
    end
  end

  assign div_valid = div_valid_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_dbz   = res_dbz_q;
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == '0) && !(|req_valid);

endmodule

// File: tb/tb_fp32_div_arbiter.sv
// Bench for fp32_div_arbiter: a behavioural divider stub drives div_result, and a
// queue-based model of grants and returns predicts every output cycle by cycle.
module tb_fp32_div_arbiter;

  localparam int N   = 4;
  localparam int DL  = 28;
  localparam int IDW = 2;
  localparam int CW  = $clog2(DL + 2);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a, req_b;
  logic [N-1:0]      req_ready;
  logic [31:0]       div_a, div_b, div_result;
  logic              div_valid;
  logic [N-1:0]      res_valid;
  logic [31:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              res_dbz;
  logic [CW-1:0]     inflight;
  logic              idle;

  always #5 clk = ~clk;

  fp32_div_arbiter #(.N(N), .DIV_LATENCY(DL), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_valid  (div_valid),
    .div_result (div_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_dbz    (res_dbz),
    .inflight   (inflight),
    .idle       (idle)
  );

  // Truncating FP32 divide for normal operands; zero denominator gives signed infinity
  function automatic logic [31:0] divq(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] num, den, q;
    int e;
    logic s;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {s, 8'hFF, 23'h0};
    num = {1'b1, a[22:0], 24'h0};
    den = {24'h0, 1'b1, b[22:0]};
    q   = num / den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[24]) return {s, 8'(e), q[23:1]};
    return {s, 8'(e - 1), q[22:0]};
  endfunction

  // Divider stub: fixed latency DL, not affected by the arbiter reset
  logic [31:0] dpipe [DL];
  logic        dv    [DL];
  always @(posedge clk) begin
    dv[0]    <= div_valid;
    dpipe[0] <= divq(div_a, div_b);
    for (int k = 1; k < DL; k++) begin
      dv[k]    <= dv[k-1];
      dpipe[k] <= dpipe[k-1];
    end
  end
  assign div_result = dv[DL-1] ? dpipe[DL-1] : 32'hDEAD_BEEF;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
    logic        dbz;
  } exp_t;

  exp_t        expq[$];
  int          dgr[$];
  int          cyc, mptr, errs, checks;
  int          ret_count, last_ret_cyc, last_acc_cyc;
  logic [31:0] e_da, e_db, h_data;
  int          h_id;
  logic        h_dbz;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    x = $urandom;
    x[30:23] = 8'($urandom_range(100, 150));
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[i]     = v;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One clock: check the grant before the edge, then every registered output after it
  task automatic tick();
    int          g;
    logic        r;
    logic [N-1:0] eg, erv;
    exp_t        e;
    int          einf;
    #1;
    r  = rst;
    g  = r ? -1 : pick(req_valid, mptr);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    for (int i = 0; i < N; i++) if (req_ready[i]) dgr.push_back(i);
    if (g >= 0) begin
      e.due  = cyc + DL + 2;
      e.id   = g;
      e.data = divq(req_a[32*g +: 32], req_b[32*g +: 32]);
      e.dbz  = (req_b[32*g +: 31] == 31'd0);
      expq.push_back(e);
      mptr = (g + 1) % N;
      e_da = req_a[32*g +: 32];
      e_db = req_b[32*g +: 32];
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      expq.delete();
      mptr = 0; e_da = '0; e_db = '0; h_data = '0; h_id = 0; h_dbz = 1'b0;
    end
    einf = expq.size();
    erv  = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      erv[e.id] = 1'b1;
      h_data = e.data; h_id = e.id; h_dbz = e.dbz;
    end
    chk("div_valid", 64'(div_valid), 64'(g >= 0));
    chk("div_a", 64'(div_a), 64'(e_da));
    chk("div_b", 64'(div_b), 64'(e_db));
    chk("res_valid", 64'(res_valid), 64'(erv));
    chk("res_data", 64'(res_data), 64'(h_data));
    chk("res_id", 64'(res_id), 64'(h_id));
    chk("res_dbz", 64'(res_dbz), 64'(h_dbz));
    chk("inflight", 64'(inflight), 64'(einf));
    chk("idle", 64'(idle), 64'((einf == 0) && (req_valid == '0)));
    if (res_valid != '0) begin
      ret_count++;
      last_ret_cyc = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int snap;
    int waited;
    errs = 0; checks = 0; cyc = 0; mptr = 0; ret_count = 0;
    last_ret_cyc = 0; last_acc_cyc = 0;
    e_da = '0; e_db = '0; h_data = '0; h_id = 0; h_dbz = 1'b0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

    // Reset values
    run(2);
    rst = 1'b0;
    run(1);

    // Single request from requester 2: 6.0 / 2.0
    set_req(2, 1'b1, 32'h40C0_0000, 32'h4000_0000);
    tick();
    req_valid = '0;
    run(35);
    chk("latency", 64'(last_ret_cyc - last_acc_cyc), 64'(30));
    chk("single_data", 64'(res_data), 64'h4040_0000);
    chk("single_id", 64'(res_id), 64'(2));

    // All four hold valid for 8 cycles from a fresh pointer
    do_reset();
    dgr.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_fp(), rnd_fp());
    run(8);
    req_valid = '0;
    run(36);
    chk("rr_count", 64'(dgr.size()), 64'(8));
    for (int i = 0; i < 8 && i < dgr.size(); i++) chk("rr_order", 64'(dgr[i]), 64'(i % N));

    // Pointer wrap: move pointer to 3, then only requesters 0 and 3
    set_req(2, 1'b1, rnd_fp(), rnd_fp());
    tick();
    req_valid = '0;
    dgr.delete();
    set_req(0, 1'b1, rnd_fp(), rnd_fp());
    set_req(3, 1'b1, rnd_fp(), rnd_fp());
    run(3);
    req_valid = '0;
    chk("wrap_count", 64'(dgr.size()), 64'(3));
    if (dgr.size() == 3) begin
      chk("wrap_g0", 64'(dgr[0]), 64'(3));
      chk("wrap_g1", 64'(dgr[1]), 64'(0));
      chk("wrap_g2", 64'(dgr[2]), 64'(3));
    end
    run(34);

    // Divide by -0
    set_req(1, 1'b1, 32'h3F80_0000, 32'h8000_0000);
    tick();
    req_valid = '0;
    run(32);
    chk("dbz_flag", 64'(res_dbz), 64'(1));
    chk("dbz_data", 64'(res_data), 64'hFF80_0000);

    // Reset 10 cycles after three accepts discards them
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, rnd_fp(), rnd_fp());
    run(3);
    req_valid = '0;
    run(10);
    do_reset();
    snap = ret_count;
    run(40);
    chk("discarded", 64'(ret_count - snap), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));

    // Steady streaming keeps inflight at DL+2, then drains to idle
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rnd_fp(), rnd_fp());
    run(45);
    chk("stream_inflight", 64'(inflight), 64'(DL + 2));
    req_valid = '0;
    waited = 0;
    while (idle !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk("drain_bound", 64'(waited <= DL + 3), 64'(1));

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] b;
        b = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : rnd_fp();
        set_req(i, ($urandom_range(0, 3) != 0), rnd_fp(), b);
      end
      tick();
    end
    req_valid = '0;
    run(35);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
